// File: rtl/bcd_pkg.sv
//------------------------------------------------------------------------------
// bcd_pkg : shared BCD digit constants and validity helper.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package bcd_pkg;

   localparam int       BCD_W   = 4;
   localparam bit [3:0] BCD_MAX = 4'd9;
   localparam bit [3:0] BCD_MIN = 4'd0;

   function automatic logic is_bcd(input logic [BCD_W-1:0] digit);
      return (digit <= BCD_MAX);
   endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit.sv
//------------------------------------------------------------------------------
// bcd_digit : one up/down BCD decade with clear, load and carry/borrow out.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bcd_digit
   import bcd_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [BCD_W-1:0] ld_digit,
   input  logic             ci,
   input  logic             up,
   output logic [BCD_W-1:0] q,
   output logic             co
);

   logic [BCD_W-1:0] r_q;
   logic             w_at_edge;

   assign w_at_edge = up ? (r_q == BCD_MAX) : (r_q == BCD_MIN);
   assign co        = ci & w_at_edge;
   assign q         = r_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_q <= BCD_MIN;
      end else if (clear) begin
         r_q <= BCD_MIN;
      end else if (load) begin
         // Out-of-range digits collapse to zero so no illegal code is stored.
         r_q <= is_bcd(ld_digit) ? ld_digit : BCD_MIN;
      end else if (ci) begin
         if (up)
            r_q <= w_at_edge ? BCD_MIN : r_q + 4'd1;
         else
            r_q <= w_at_edge ? BCD_MAX : r_q - 4'd1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/bcd_counter_multi.sv
//------------------------------------------------------------------------------
// bcd_counter_multi : DIGITS-decade up/down BCD counter with wrap/saturate mode.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bcd_counter_multi
   import bcd_pkg::*;
#(
   parameter int DIGITS = 2,
   parameter bit WRAP   = 1'b1
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  en,
   input  logic                  up,
   output logic [4*DIGITS-1:0]   dout,
   output logic                  tc,
   output logic                  rollover,
   output logic                  load_err
);

   logic [DIGITS-1:0] w_ci;
   logic [DIGITS-1:0] w_co;
   logic              w_at_term;
   logic              w_bad_digit;
   logic              w_cnt_en;
   logic              r_rollover;
   logic              r_load_err;

   always_comb begin
      w_at_term   = 1'b1;
      w_bad_digit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (dout[4*i +: 4] != (up ? BCD_MAX : BCD_MIN))
            w_at_term = 1'b0;
         if (!is_bcd(load_val[4*i +: 4]))
            w_bad_digit = 1'b1;
      end
   end

   assign tc = en & w_at_term;

   // Saturating mode kills the whole chain at the terminal value so nothing moves.
   assign w_cnt_en = en & ~(~WRAP & w_at_term);

   generate
      for (genvar i = 0; i < DIGITS; i++) begin : g_digit
         if (i == 0) begin : g_lsd
            assign w_ci[i] = w_cnt_en;
         end else begin : g_upper
            assign w_ci[i] = w_co[i-1];
         end

         bcd_digit u_digit (
            .clk      (clk),
            .reset    (reset),
            .clear    (clear),
            .load     (load),
            .ld_digit (load_val[4*i +: 4]),
            .ci       (w_ci[i]),
            .up       (up),
            .q        (dout[4*i +: 4]),
            .co       (w_co[i])
         );
      end
   endgenerate

   // MSD carry-out is only non-zero on an actual wrap of the full count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rollover <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_rollover <= w_co[DIGITS-1] & ~clear & ~load;
         r_load_err <= load & ~clear & w_bad_digit;
      end
   end

   assign rollover = r_rollover;
   assign load_err = r_load_err;

endmodule

`default_nettype wire

// File: doc/bcd_counter_multi.md
Name: bcd_counter_multi

Overview:
- Parametrised multi-decade BCD counter.
- Successor to the single-digit 0-9 counter; the count is carried across DIGITS decades.
- Adds enable, up/down direction, synchronous clear, parallel load with BCD validation, and a wrap/saturate mode.
- Provides a combinational terminal-count output for cascading counters and a registered rollover pulse for display/timer logic.

Parameters:
- DIGITS, 2, number of BCD decades; legal range 1-8; count range 0 to 10^DIGITS-1.
- WRAP, 1, 1 = modulo wrap at the terminal value; 0 = saturate at the terminal value.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  reset, asynchronous, active-low.
- clear  input  1  synchronous clear to zero.
- load  input  1  synchronous parallel load of load_val.
- load_val  input  4*DIGITS  BCD load value; digit i occupies bits [4i+3:4i].
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- dout  output  4*DIGITS  current BCD count; digit 0 is the LSD.
- tc  output  1  combinational terminal count.
- rollover  output  1  registered one-cycle pulse.
- load_err  output  1  registered one-cycle pulse on an invalid load digit.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. While reset=0: dout=0, rollover=0, load_err=0, independent of clk. Deassertion takes effect at the next rising clk edge.
- Priority per rising edge: clear > load > en. When none is active, dout holds.
- clear: dout<=0. rollover and load_err are 0 that cycle.
- load: each digit of load_val that is <=9 is loaded as-is. Any digit >9 is loaded as 0 and load_err pulses high for the next cycle. Valid digits are still loaded. en is ignored in a load cycle.
- Count, up=1 (en=1): LSD increments. A digit at 9 goes to 0 and carries into the next digit. Carry ripples combinationally within one cycle, so the whole count updates in 1 cycle.
- Count, up=0 (en=1): LSD decrements. A digit at 0 goes to 9 and borrows from the next digit.
- Terminal value: all 9s when up=1, all 0s when up=0.
- tc = en & (dout == terminal value for the current up). It is combinational and valid in the same cycle, so tc feeds the en of a downstream counter.
- At the terminal value with en=1:
  - WRAP=1: all 9s -> all 0s when up=1; all 0s -> all 9s when up=0. rollover=1 in the following cycle.
  - WRAP=0: dout holds and rollover stays 0.
- A direction change mid-count takes effect on the same edge; there is no extra latency.
- All dout digits are always within 0-9; no illegal BCD state is reachable.
- Async reset during a ripple or a load cycle: the reset result wins and the pending update is discarded.

Decomposition:
- Package bcd_pkg holds:
  - BCD_MAX = 4'd9, BCD_MIN = 4'd0, digit width constant 4.
  - Function is_bcd(digit) returning digit <= 9.
- Sub-module bcd_digit holds one decade register.
  - Inputs: clk, reset, clear, load, ld_digit, ci (count enable/carry in), up.
  - Outputs: q[3:0], co, where co = ci & (q==9 when up, q==0 when down).
- The top level instantiates DIGITS bcd_digit instances in a generate loop with ci[i+1]=co[i] and ci[0]=en.
- The top level also holds the WRAP gating, the rollover register and the load_err logic.

Test Plan:
- Reset: drive reset=0 mid-count at dout=8'h37 (DIGITS=2) -> dout=8'h00 immediately without a clock edge; after release with en=1, up=1, ten clocks give dout=8'h10.
- Decade ripple: load 8'h09, en=1, up=1, one clock -> dout=8'h10 and rollover=0. Then load 8'h10, up=0, one clock -> dout=8'h09.
- Wrap, WRAP=1:
  - From 8'h99, up=1: tc=1 before the edge; after the edge dout=8'h00, rollover=1 for exactly one cycle.
  - From 8'h00, up=0: dout=8'h99 with a rollover pulse.
- Saturate, WRAP=0: from 8'h99, up=1, five clocks -> dout stays 8'h99, tc=1 throughout, rollover never asserts.
- Load validation: load_val=8'h4A -> dout=8'h40 and load_err=1 for one cycle. load_val=8'h47 -> dout=8'h47 and load_err=0.
- Priority: clear=1, load=1, en=1 on the same edge from 8'h55 -> dout=8'h00. Then load=1, en=1 with load_val=8'h23 -> dout=8'h23, not 8'h24.
